// File: rtl/alu_op_issuer.sv
// RV32I ALU-op issue stage: decodes an instruction into ALU operands and op code
// behind a one-deep valid/ready output register, with a saturating illegal-op counter.
module alu_op_issuer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] srcA,
    output logic [31:0] srcB,
    output logic [3:0]  alu_ctrl,
    output logic [4:0]  rd,
    output logic        illegal,
    output logic [15:0] illegal_count
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_BRANCH = 7'b1100011
    } opcode_e;

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic        unused_rs1_field;

    alu_op_e     dec_op;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [4:0]  dec_rd;
    logic        dec_illegal;

    logic        transfer;

    logic        out_valid_q, out_valid_d;
    logic [31:0] src_a_q, src_a_d;
    logic [31:0] src_b_q, src_b_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic [4:0]  rd_q, rd_d;
    logic        illegal_q, illegal_d;
    logic [15:0] illegal_count_q, illegal_count_d;

    assign funct3           = instr[14:12];
    assign funct7           = instr[31:25];
    assign imm_i            = {{20{instr[31]}}, instr[31:20]};
    assign imm_s            = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u            = {instr[31:12], 12'h000};
    assign shamt            = {27'd0, instr[24:20]};
    // rs1 index is resolved upstream; only its data arrives here
    assign unused_rs1_field = ^instr[19:15];

    always_comb begin
        dec_illegal = 1'b0;
        dec_op      = ALU_ADD;
        dec_a       = rs1_data;
        dec_b       = rs2_data;
        dec_rd      = instr[11:7];
        case (instr[6:0])
            OPC_OP: begin
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec_op = ALU_ADD;
                    {7'b0100000, 3'b000}: dec_op = ALU_SUB;
                    {7'b0000000, 3'b001}: dec_op = ALU_SLL;
                    {7'b0000000, 3'b010}: dec_op = ALU_SLT;
                    {7'b0000000, 3'b011}: dec_op = ALU_SLTU;
                    {7'b0000000, 3'b100}: dec_op = ALU_XOR;
                    {7'b0000000, 3'b101}: dec_op = ALU_SRL;
                    {7'b0100000, 3'b101}: dec_op = ALU_SRA;
                    {7'b0000000, 3'b110}: dec_op = ALU_OR;
                    {7'b0000000, 3'b111}: dec_op = ALU_AND;
                    default:              dec_illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec_b = imm_i;
                case (funct3)
                    3'b000: dec_op = ALU_ADD;
                    3'b010: dec_op = ALU_SLT;
                    3'b011: dec_op = ALU_SLTU;
                    3'b100: dec_op = ALU_XOR;
                    3'b110: dec_op = ALU_OR;
                    3'b111: dec_op = ALU_AND;
                    3'b001: begin
                        dec_b = shamt;
                        if (funct7 == 7'b0000000) dec_op = ALU_SLL;
                        else                      dec_illegal = 1'b1;
                    end
                    default: begin
                        dec_b = shamt;
                        if (funct7 == 7'b0000000)      dec_op = ALU_SRL;
                        else if (funct7 == 7'b0100000) dec_op = ALU_SRA;
                        else                           dec_illegal = 1'b1;
                    end
                endcase
            end
            OPC_LOAD: dec_b = imm_i;
            OPC_STORE: begin
                dec_b  = imm_s;
                dec_rd = '0;
            end
            OPC_LUI: begin
                dec_a = '0;
                dec_b = imm_u;
            end
            OPC_AUIPC: begin
                dec_a = pc;
                dec_b = imm_u;
            end
            OPC_BRANCH: begin
                dec_rd = '0;
                case (funct3[2:1])
                    2'b00:   dec_op = ALU_SUB;
                    2'b10:   dec_op = ALU_SLT;
                    2'b11:   dec_op = ALU_SLTU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        // undecodable words still issue, as a harmless zero ADD flagged illegal
        if (dec_illegal) begin
            dec_op = ALU_ADD;
            dec_a  = '0;
            dec_b  = '0;
            dec_rd = '0;
        end
    end

    assign in_ready = !out_valid_q || out_ready;
    assign transfer = in_valid && in_ready;

    always_comb begin
        out_valid_d     = out_valid_q;
        src_a_d         = src_a_q;
        src_b_d         = src_b_q;
        alu_ctrl_d      = alu_ctrl_q;
        rd_d            = rd_q;
        illegal_d       = illegal_q;
        illegal_count_d = illegal_count_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            src_a_d     = dec_a;
            src_b_d     = dec_b;
            alu_ctrl_d  = dec_op;
            rd_d        = dec_rd;
            illegal_d   = dec_illegal;
            if (dec_illegal && (illegal_count_q != '1)) begin
                illegal_count_d = illegal_count_q + 16'd1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q     <= 1'b0;
            src_a_q         <= '0;
            src_b_q         <= '0;
            alu_ctrl_q      <= '0;
            rd_q            <= '0;
            illegal_q       <= 1'b0;
            illegal_count_q <= '0;
        end else begin
            out_valid_q     <= out_valid_d;
            src_a_q         <= src_a_d;
            src_b_q         <= src_b_d;
            alu_ctrl_q      <= alu_ctrl_d;
            rd_q            <= rd_d;
            illegal_q       <= illegal_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign srcA          = src_a_q;
    assign srcB          = src_b_q;
    assign alu_ctrl      = alu_ctrl_q;
    assign rd            = rd_q;
    assign illegal       = illegal_q;
    assign illegal_count = illegal_count_q;

endmodule
